// File: rtl/adc_mon_pkg.sv
// Shared constants, FSM state type and helpers for the ADC sample monitor.
package adc_mon_pkg;

  localparam int unsigned ADC_W = 12;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EVAL  = 2'd2
  } mon_state_e;

  // Increment that holds at lim once reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                              input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/adc_window_avg.sv
// Windowed accumulator: sums 2^N_AVG_LOG2 samples and publishes the truncated mean.
module adc_window_avg
  import adc_mon_pkg::*;
#(
  parameter int unsigned N_AVG_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] sample_in,
  input  logic             sample_valid,
  output logic [ADC_W-1:0] avg_out,
  output logic             avg_valid,
  output logic             win_done_c
);

  localparam int unsigned ACC_W  = ADC_W + N_AVG_LOG2;
  localparam int unsigned SCNT_W = N_AVG_LOG2 + 1;
  localparam logic [SCNT_W-1:0] WIN_LEN = SCNT_W'(1) << N_AVG_LOG2;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum_c;
  logic [SCNT_W-1:0] cnt;
  logic [SCNT_W-1:0] cnt_inc_c;

  assign acc_sum_c  = acc + ACC_W'(sample_in);
  assign cnt_inc_c  = cnt + SCNT_W'(1);
  assign win_done_c = sample_valid && (cnt_inc_c == WIN_LEN);

  // Completing sample closes the window and restarts it on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (sample_valid) begin
        if (win_done_c) begin
          acc       <= '0;
          cnt       <= '0;
          avg_out   <= ADC_W'(acc_sum_c >> N_AVG_LOG2);
          avg_valid <= 1'b1;
        end else begin
          acc <= acc_sum_c;
          cnt <= cnt_inc_c;
        end
      end
    end
  end

endmodule

// File: rtl/adc_sample_monitor.sv
// ADC sample monitor: window averaging with range check, consecutive-violation
// counter and sticky fault flag.
module adc_sample_monitor
  import adc_mon_pkg::*;
#(
  parameter int unsigned N_AVG_LOG2   = 4,
  parameter int unsigned FAULT_CONSEC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] sample_in,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] thr_low,
  input  logic [ADC_W-1:0] thr_high,
  input  logic             fault_clr,
  output logic [ADC_W-1:0] avg_out,
  output logic             avg_valid,
  output logic             fault,
  output logic [CNT_W-1:0] consec_cnt
);

  localparam logic [CNT_W-1:0] CONSEC_LIM = CNT_W'(FAULT_CONSEC);

  mon_state_e       state;
  mon_state_e       state_next;
  logic [CNT_W-1:0] consec_next;
  logic             fault_next;
  logic             oor_c;
  logic [CNT_W-1:0] inc_c;
  logic             set_c;
  logic             win_done_c;

  adc_window_avg #(
    .N_AVG_LOG2 (N_AVG_LOG2)
  ) u_window_avg (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .win_done_c   (win_done_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      consec_cnt <= '0;
      fault      <= 1'b0;
    end else begin
      state      <= state_next;
      consec_cnt <= consec_next;
      fault      <= fault_next;
    end
  end

  // Next state plus range evaluation; a set condition outranks fault_clr.
  always_comb begin
    state_next  = state;
    consec_next = consec_cnt;
    fault_next  = fault;
    oor_c       = 1'b0;
    inc_c       = '0;
    set_c       = 1'b0;

    unique case (state)
      IDLE:    if (sample_valid) state_next = win_done_c ? EVAL : ACCUM;
      ACCUM:   if (win_done_c) state_next = EVAL;
      EVAL:    state_next = ACCUM;
      default: state_next = IDLE;
    endcase

    if (state == EVAL) begin
      oor_c = (avg_out < thr_low) || (avg_out > thr_high);
      inc_c = oor_c ? sat_inc(consec_cnt, CONSEC_LIM) : '0;
      set_c = oor_c && (inc_c == CONSEC_LIM);
    end

    if (fault_clr && set_c) begin
      fault_next  = 1'b1;
      consec_next = inc_c;
    end else if (fault_clr) begin
      fault_next  = 1'b0;
      consec_next = '0;
    end else if (state == EVAL) begin
      consec_next = inc_c;
      fault_next  = fault | set_c;
    end
  end

endmodule

// File: doc/adc_sample_monitor.md
ADC_SAMPLE_MONITOR -- requirements
Module: adc_sample_monitor

Interface
REQ-001 Parameter N_AVG_LOG2, default 4, log2 of the number of samples per averaging window (1..6).
REQ-002 Parameter FAULT_CONSEC, default 3, number of consecutive out-of-range averages that raise fault (1..15).
REQ-003 clk  input  1  50 MHz system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 sample_in  input  12  ADC code from the upstream serial ADC capture stage, MSB first already assembled.
REQ-006 sample_valid  input  1  one-cycle strobe; sample_in is valid in that cycle; back-to-back strobes allowed.
REQ-007 thr_low  input  12  lower in-range bound, inclusive, sampled in EVAL cycle.
REQ-008 thr_high  input  12  upper in-range bound, inclusive, sampled in EVAL cycle.
REQ-009 fault_clr  input  1  level/pulse; clears fault and consecutive counter.
REQ-010 avg_out  output  12  last completed window average.
REQ-011 avg_valid  output  1  one-cycle pulse when avg_out updates.
REQ-012 fault  output  1  sticky out-of-range flag (drives board LED).
REQ-013 consec_cnt  output  4  current consecutive out-of-range count, saturating at FAULT_CONSEC.

Function
REQ-014 FSM states IDLE, ACCUM, EVAL; IDLE -> ACCUM on first sample_valid after reset; ACCUM -> EVAL on the edge capturing sample number 2^N_AVG_LOG2; EVAL -> ACCUM unconditionally after one cycle.
REQ-015 Accumulator width 12+N_AVG_LOG2 bits; unsigned add; no overflow possible by construction.
REQ-016 Sample counter width N_AVG_LOG2+1; window completes at count 2^N_AVG_LOG2, then counter and accumulator restart in the same edge (no sample dropped).
REQ-017 sample_valid during EVAL counts as first sample of the next window.
REQ-018 avg_out = accumulator >> N_AVG_LOG2 (truncation, no rounding), registered; avg_out and avg_valid appear 1 cycle after the edge capturing the last window sample.
REQ-019 Out-of-range when avg_out < thr_low or avg_out > thr_high; equality is in range; thr_low > thr_high makes every average out of range.
REQ-020 In EVAL: out-of-range increments consec_cnt (saturating at FAULT_CONSEC); in-range clears it to 0; consec_cnt and fault update at the end of EVAL, visible 2 cycles after the last sample edge.
REQ-021 fault sets when consec_cnt reaches FAULT_CONSEC and stays set until fault_clr.
REQ-022 fault_clr clears fault and consec_cnt; when fault_clr coincides with an EVAL producing a set condition, set wins and consec_cnt takes the incremented value.
REQ-023 Averaging and avg_valid continue while fault is set.

Reset
REQ-024 rst low asynchronously forces: state IDLE, accumulator 0, sample counter 0, avg_out 0, avg_valid 0, consec_cnt 0, fault 0.
REQ-025 Reset mid-window discards the partial window; first sample after release starts a fresh window.

Structure
REQ-026 Package adc_mon_pkg holds the FSM state enum, ADC_W=12 and CNT_W=4 constants.
REQ-027 Sub-module adc_window_avg implements accumulator, sample counter and avg_out/avg_valid; top holds FSM, comparator, consec_cnt, fault.
REQ-028 Target 150-300 lines RTL total.

Verification
REQ-029 16 strobes of 12'd1000, thr 900/1100 -> one avg_valid pulse, avg_out=1000, fault=0, consec_cnt=0.
REQ-030 Samples 0..15 (sum 120) -> avg_out=7 (truncated); 16 strobes at 12'hFFF -> avg_out=12'hFFF, no overflow.
REQ-031 Three windows avg 1200, thr 900/1100 -> consec_cnt 1,2,3; fault rises 2 cycles after 48th strobe; fourth window avg 1000 -> consec_cnt 0, fault stays 1.
REQ-032 fault_clr asserted in same cycle as third out-of-range EVAL -> fault=1 (set wins); later fault_clr alone -> fault=0, consec_cnt=0.
REQ-033 Continuous every-cycle strobes for 64 cycles -> exactly 4 avg_valid pulses 16 cycles apart, no lost sample.
REQ-034 rst pulsed low after 7 samples -> all outputs 0 immediately; next 16 samples of 500 -> avg_out=500.
